// File: rtl/sseg_pkg.sv
// Shared constants and types for the binary-to-seven-segment scanner.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package sseg_pkg;

  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0010000;
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  // Conversion FSM: idle, or running the double-dabble shifts.
  typedef enum logic [0:0] {StIdle, StConv} conv_state_e;

  // 10^n, used to derive the largest displayable value at elaboration.
  function automatic int unsigned pow10(int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/sseg_digit_decode.sv
// Combinational BCD nibble to seven-segment decoder.
// Ports:
//   bcd   - BCD digit; codes 10-15 decode to blank
//   blank - force all segments off
//   dash  - force the dash pattern (takes priority over blank)
//   seg   - active-low segments {g,f,e,d,c,b,a}
module sseg_digit_decode
  import sseg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SegBlank;
    if (dash) begin
      seg = SegDash;
    end else if (!blank) begin
      case (bcd)
        4'd0:    seg = Seg0;
        4'd1:    seg = Seg1;
        4'd2:    seg = Seg2;
        4'd3:    seg = Seg3;
        4'd4:    seg = Seg4;
        4'd5:    seg = Seg5;
        4'd6:    seg = Seg6;
        4'd7:    seg = Seg7;
        4'd8:    seg = Seg8;
        4'd9:    seg = Seg9;
        default: seg = SegBlank;
      endcase
    end
  end

endmodule

// File: rtl/bin2sseg_scan.sv
// Binary to multiplexed seven-segment display driver.
// A load strobe captures bin_in and starts a sequential double-dabble conversion; the
// result is committed to the display register in one step when the conversion ends.
// A free-running scan lights one digit at a time, SCAN_DIV cycles each.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   bin_in - unsigned value to display
//   load   - single-cycle strobe, ignored while busy
//   busy   - conversion in progress
//   ovf    - displayed value exceeds 10^N_DIGITS-1 (all digits show a dash)
//   seg    - active-low segments {g,f,e,d,c,b,a}, registered
//   an     - active-low digit enables, one-hot-low, registered
module bin2sseg_scan
  import sseg_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIN_W-1:0]    bin_in,
  input  logic                load,
  output logic                busy,
  output logic                ovf,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an
);

  localparam int unsigned CntW   = $clog2(BIN_W + 1);
  localparam int unsigned ScanW  = $clog2(SCAN_DIV);
  localparam int unsigned IdxW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned BcdW   = 4 * N_DIGITS;
  localparam int unsigned MaxVal = pow10(N_DIGITS) - 1;

  conv_state_e         state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [BcdW-1:0]     disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic [ScanW-1:0]    scan_q, scan_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [6:0]          seg_q;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic [BcdW-1:0]     bcd_adj;
  logic [BcdW-1:0]     bcd_shift;
  logic [3:0]          cur_bcd;
  logic                cur_blank;
  logic                zero_run;
  logic [6:0]          seg_dec;

  // Double-dabble step. Only N_DIGITS nibbles are kept: carries out of the top nibble
  // occur only for out-of-range values, which display as dashes anyway.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = BcdW'({bcd_adj, bin_q[BIN_W-1]});
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          bin_d      = bin_in;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = 32'(bin_in) > MaxVal;
          state_d    = StConv;
        end
      end
      StConv: begin
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        bcd_d = bcd_shift;
        cnt_d = cnt_q + CntW'(1);
        // Commit the final shift result straight into the display register.
        if (cnt_q == CntW'(BIN_W - 1)) begin
          disp_d  = bcd_shift;
          ovf_d   = ovf_pend_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    scan_d = scan_q + ScanW'(1);
    idx_d  = idx_q;
    if (scan_q == ScanW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IdxW'(N_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Decode from next-state values so seg/an registers always match disp_q/idx_q.
  always_comb begin
    zero_run  = 1'b1;
    cur_bcd   = '0;
    cur_blank = 1'b0;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp_d[4*i +: 4] == 4'd0);
      if (idx_d == IdxW'(i)) begin
        cur_bcd   = disp_d[4*i +: 4];
        cur_blank = (BLANK_LZ != 0) && (i != 0) && zero_run;
      end
    end
    an_d = ~(N_DIGITS'(1) << idx_d);
  end

  sseg_digit_decode u_decode (
    .bcd   (cur_bcd),
    .blank (cur_blank),
    .dash  (ovf_d),
    .seg   (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      scan_q     <= '0;
      idx_q      <= '0;
      seg_q      <= Seg0;
      an_q       <= ~N_DIGITS'(1);
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      seg_q      <= seg_dec;
      an_q       <= an_d;
    end
  end

  assign busy = (state_q == StConv);
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_bin2sseg_scan.sv
module tb_bin2sseg_scan;

  localparam int unsigned ND  = 4;
  localparam int unsigned BW  = 14;
  localparam int unsigned SD  = 4;

  logic          clk;
  logic          rst;
  logic [BW-1:0] bin_in;
  logic          load;
  logic          busy, ovf, busy_nb, ovf_nb;
  logic [6:0]    seg, seg_nb;
  logic [ND-1:0] an, an_nb;

  int unsigned m_cyc;
  int unsigned exp_val;
  bit          exp_ovf;
  int          n_checks;
  int          n_errors;

  bin2sseg_scan #(.N_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD), .BLANK_LZ(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bin_in (bin_in),
    .load   (load),
    .busy   (busy),
    .ovf    (ovf),
    .seg    (seg),
    .an     (an)
  );

  bin2sseg_scan #(.N_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD), .BLANK_LZ(0)) dut_nb (
    .clk    (clk),
    .rst    (rst),
    .bin_in (bin_in),
    .load   (load),
    .busy   (busy_nb),
    .ovf    (ovf_nb),
    .seg    (seg_nb),
    .an     (an_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since the last reset edge; drives the expected scan position.
  always @(posedge clk) begin
    if (rst) m_cyc <= 0;
    else     m_cyc <= m_cyc + 1;
  end

  function automatic int unsigned cur_idx();
    return (m_cyc / SD) % ND;
  endfunction

  function automatic logic [ND-1:0] exp_an(int unsigned idx);
    logic [ND-1:0] one;
    one = 1;
    return ~(one << idx);
  endfunction

  function automatic logic [6:0] exp_seg(int unsigned val, bit ov, int unsigned dig, bit blz);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < dig; i++) p = p * 10;
    if (ov) return 7'b0111111;
    if (blz && dig != 0 && val < p) return 7'b1111111;
    case ((val / p) % 10)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  task automatic do_load(input int unsigned v);
    @(posedge clk); #1;
    bin_in = BW'(v);
    load   = 1'b1;
    @(posedge clk); #1;
    load   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; bin_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (an !== 4'b1110) begin
      n_errors++; $display("FAIL reset_an: got %b expected 1110", an);
    end
    n_checks++;
    if (seg !== 7'b1000000) begin
      n_errors++; $display("FAIL reset_seg: got %b expected 1000000", seg);
    end
    n_checks++;
    if (busy !== 1'b0 || ovf !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags: got busy=%b ovf=%b expected 0 0", busy, ovf);
    end
    exp_val = 0; exp_ovf = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an(cur_idx()) || seg !== exp_seg(0, 0, cur_idx(), 1)) begin
        n_errors++;
        $display("FAIL reset_scan: got an=%b seg=%b expected an=%b seg=%b", an, seg,
                 exp_an(cur_idx()), exp_seg(0, 0, cur_idx(), 1));
      end
    end
  endtask

  task automatic test_conversion();
    int n;
    do_load(1234);
    // Display must keep the old value while busy.
    n = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      n_checks++;
      if (seg !== exp_seg(exp_val, exp_ovf, cur_idx(), 1)) begin
        n_errors++;
        $display("FAIL conv_hold: got seg=%b expected %b", seg,
                 exp_seg(exp_val, exp_ovf, cur_idx(), 1));
      end
    end
    n_checks++;
    if (n != 14) begin
      n_errors++; $display("FAIL conv_busy_len: got %0d busy cycles expected 14", n);
    end
    @(negedge clk);
    exp_val = 1234; exp_ovf = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL conv_busy_fall: got busy=%b expected 0", busy);
    end
    n_checks++;
    if (seg !== exp_seg(exp_val, exp_ovf, cur_idx(), 1)) begin
      n_errors++; $display("FAIL conv_update_c15: got seg=%b expected %b", seg,
                           exp_seg(exp_val, exp_ovf, cur_idx(), 1));
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an(cur_idx()) || seg !== exp_seg(1234, 0, cur_idx(), 1)) begin
        n_errors++;
        $display("FAIL conv_scan_1234: got an=%b seg=%b expected an=%b seg=%b", an, seg,
                 exp_an(cur_idx()), exp_seg(1234, 0, cur_idx(), 1));
      end
    end
  endtask

  task automatic test_blanking();
    int n;
    do_load(7);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 30) begin n++; @(negedge clk); end
    n_checks++;
    if (n != 14) begin
      n_errors++; $display("FAIL blank_busy_len: got %0d expected 14", n);
    end
    exp_val = 7; exp_ovf = 0;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (cur_idx() == 0 && seg !== 7'b1111000) begin
        n_errors++; $display("FAIL blank_d0: got %b expected 1111000", seg);
      end else if (cur_idx() != 0 && seg !== 7'b1111111) begin
        n_errors++; $display("FAIL blank_lz: got %b expected 1111111", seg);
      end
      n_checks++;
      if (an_nb !== exp_an(cur_idx()) || seg_nb !== exp_seg(7, 0, cur_idx(), 0)) begin
        n_errors++;
        $display("FAIL noblank_scan: got an=%b seg=%b expected an=%b seg=%b", an_nb, seg_nb,
                 exp_an(cur_idx()), exp_seg(7, 0, cur_idx(), 0));
      end
      @(negedge clk);
    end
    n_checks++;
    if (busy_nb !== 1'b0 || ovf_nb !== 1'b0) begin
      n_errors++; $display("FAIL noblank_flags: got busy=%b ovf=%b expected 0 0", busy_nb, ovf_nb);
    end
  endtask

  task automatic test_overflow();
    int n;
    do_load(10000);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 30) begin n++; @(negedge clk); end
    n_checks++;
    if (n != 14 || ovf !== 1'b1) begin
      n_errors++; $display("FAIL ovf_set: got busy_len=%0d ovf=%b expected 14 1", n, ovf);
    end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (seg !== 7'b0111111 || an !== exp_an(cur_idx())) begin
        n_errors++; $display("FAIL ovf_dash: got seg=%b an=%b expected 0111111 %b", seg, an,
                             exp_an(cur_idx()));
      end
      @(negedge clk);
    end
    do_load(9999);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 30) begin n++; @(negedge clk); end
    exp_val = 9999; exp_ovf = 0;
    n_checks++;
    if (n != 14 || ovf !== 1'b0) begin
      n_errors++; $display("FAIL ovf_clear: got busy_len=%0d ovf=%b expected 14 0", n, ovf);
    end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (seg !== 7'b0010000) begin
        n_errors++; $display("FAIL ovf_9999: got seg=%b expected 0010000", seg);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_load(42);
    @(posedge clk);
    @(posedge clk); #1;
    bin_in = BW'(99);
    load   = 1'b1;
    @(posedge clk); #1;
    load   = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 30) begin n++; @(negedge clk); end
    // Load sampled at cycle 3; busy must still end on cycle 15 of the first conversion.
    n_checks++;
    if (n != 11) begin
      n_errors++; $display("FAIL b2b_busy_len: got %0d remaining busy cycles expected 11", n);
    end
    exp_val = 42; exp_ovf = 0;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (busy !== 1'b0 || seg !== exp_seg(42, 0, cur_idx(), 1)) begin
        n_errors++; $display("FAIL b2b_display: got busy=%b seg=%b expected 0 %b", busy, seg,
                             exp_seg(42, 0, cur_idx(), 1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_load(5555);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_val = 0; exp_ovf = 0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || ovf !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_flags: got busy=%b ovf=%b expected 0 0", busy, ovf);
    end
    n_checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      n_errors++; $display("FAIL rstmid_first: got an=%b seg=%b expected 1110 1000000", an, seg);
    end
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || an !== exp_an(cur_idx()) || seg !== exp_seg(0, 0, cur_idx(), 1)) begin
        n_errors++;
        $display("FAIL rstmid_scan: got busy=%b an=%b seg=%b expected 0 %b %b", busy, an, seg,
                 exp_an(cur_idx()), exp_seg(0, 0, cur_idx(), 1));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst    = 1'b1;
    load   = 1'b0;
    bin_in = '0;
    test_reset();
    test_conversion();
    test_blanking();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bin2sseg_scan.md
BIN2SSEG_SCAN -- requirements
Module: bin2sseg_scan

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4: number of multiplexed digits (1..8).
REQ-002 SHALL have parameter BIN_W, default 14: binary input width (4..27).
REQ-003 SHALL have parameter SCAN_DIV, default 50000: clock cycles each digit is lit (>=2).
REQ-004 SHALL have parameter BLANK_LZ, default 1: 1 enables leading-zero blanking.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 bin_in  in  BIN_W  unsigned value to display.
REQ-009 load  in  1  single-cycle strobe that captures bin_in.
REQ-010 busy  out  1  high while a conversion is in progress.
REQ-011 ovf  out  1  high while the displayed value exceeds 10^N_DIGITS-1.
REQ-012 seg  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-013 an  out  N_DIGITS  active-low digit enables, one-hot-low.

Function
REQ-014 FSM states SHALL be IDLE and CONV; load in IDLE captures bin_in, clears the BCD shift register, and enters CONV.
REQ-015 CONV SHALL run sequential double-dabble for exactly BIN_W cycles: add 3 to every nibble >=5, then shift left one bit.
REQ-016 On the cycle after the last shift, the display register SHALL update atomically, the FSM SHALL return to IDLE, and busy SHALL fall.
REQ-017 Load-to-display latency SHALL be BIN_W+1 cycles; busy SHALL be high for exactly BIN_W cycles, starting the cycle after load.
REQ-018 load while busy=1 SHALL be ignored; there is no queuing.
REQ-019 The display register SHALL hold its value between conversions, and scanning SHALL never show partial conversion results.
REQ-020 Overflow SHALL be decided at capture as bin_in > 10^N_DIGITS-1; if true, ovf SHALL rise with the display update and every digit SHALL show dash (seg=0111111).
REQ-021 A later in-range conversion SHALL clear ovf at its display update.
REQ-022 Scan counter SHALL count 0..SCAN_DIV-1; at terminal count it SHALL wrap to 0 and the digit index SHALL advance, wrapping N_DIGITS-1 to 0.
REQ-023 an[i] SHALL be 0 only for the current digit index i; digit 0 is least significant.
REQ-024 Digit codes 0-9 SHALL map to 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; blank SHALL be 1111111.
REQ-025 With BLANK_LZ=1, every zero digit above the most significant nonzero digit SHALL be blank, and digit 0 SHALL never be blanked.
REQ-026 seg and an SHALL be registered and change in the same cycle, with no glitch cycle between them.
REQ-027 Scanning SHALL continue unaffected by load, busy or conversion.

Reset
REQ-028 On rst: FSM=IDLE, busy=0, ovf=0, display register=0, scan counter=0, digit index=0.
REQ-029 The first cycle after reset SHALL present an=~1 and seg=1000000.
REQ-030 rst mid-conversion SHALL abort the conversion and discard the captured value.

Structure
REQ-031 Package sseg_pkg SHALL hold the segment constants (digits 0-9, BLANK, DASH) and the FSM state typedef.
REQ-032 One sub-module, sseg_digit_decode, SHALL be combinational: inputs bcd[3:0], blank, dash; output seg[6:0]; codes 10-15 decode to blank.
REQ-033 The shift counter width SHALL be clog2(BIN_W+1) and the scan counter width SHALL be clog2(SCAN_DIV).

Verification (N_DIGITS=4, BIN_W=14, SCAN_DIV=4)
REQ-034 Reset -> an=1110, seg=1000000; digits 1-3 blank over a full 16-cycle scan; busy=0.
REQ-035 load bin_in=1234 -> busy high for 14 cycles; display updates at cycle 15; scan shows 4,3,2,1 with each digit held 4 cycles.
REQ-036 load 7 -> digit 0 = 1111000, digits 1-3 = 1111111; with BLANK_LZ=0, digits 1-3 = 1000000.
REQ-037 load 10000 -> ovf=1 and all digits 0111111; then load 9999 -> ovf=0 and all digits 0010000.
REQ-038 load 42, then load 99 three cycles later -> second load ignored and 42 displayed; rst asserted at cycle 5 of a conversion of 5555 -> display 0, busy=0.
